xulie_ser: RTL and testbench

Parallel-to-serial frame source for the `1110` sequence-detector path. It accepts a parallel word under a ready/load handshake and shifts it out MSB-first, one bit per clock, on `dout`, which drives the detector's `Din`. Between frames it holds the line at 0, so idle gaps never create false `1110` hits. It also raises `done` when a frame completes and reports via `ready` when a new word may be loaded.

---
 rtl/xulie_ser_pkg.sv | 16 +
 rtl/xulie_ser_if.sv | 38 +++
 rtl/xulie_ser.sv | 103 ++++++++++
 tb/tb_xulie_ser.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/xulie_ser_pkg.sv
// Shared definitions for the xulie serial frame source: FSM state type,
// idle line level and default frame width.
package xulie_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } xulie_ser_state_t;

   // Line level held on dout between frames; 0 keeps idle gaps from
   // looking like part of a 1110 sequence.
   localparam logic XULIE_IDLE_LEVEL = 1'b0;

   localparam int XULIE_SER_WIDTH_DEF = 16;

endpackage

// File: rtl/xulie_ser_if.sv
// Load/serial-out bundle for xulie_ser. The frame_cnt signal exists only
// when XULIE_SER_CNT_EN is defined.
interface xulie_ser_if
   import xulie_pkg::*;
#(
   parameter int WIDTH = XULIE_SER_WIDTH_DEF
);
   logic             load;
   logic [WIDTH-1:0] pdata;
   logic             ready;
   logic             dout;
   logic             dvalid;
   logic             done;
`ifdef XULIE_SER_CNT_EN
   logic [7:0]       frame_cnt;

   modport master (
      output load, pdata,
      input  ready, dout, dvalid, done, frame_cnt
   );

   modport slave (
      input  load, pdata,
      output ready, dout, dvalid, done, frame_cnt
   );
`else
   modport master (
      output load, pdata,
      input  ready, dout, dvalid, done
   );

   modport slave (
      input  load, pdata,
      output ready, dout, dvalid, done
   );
`endif

endinterface

// File: rtl/xulie_ser.sv
// Parallel-to-serial frame source: loads a WIDTH-bit word when idle and
// shifts it out MSB-first, one bit per clock, then pulses done for one
// cycle. Optional completed-frame counter enabled by XULIE_SER_CNT_EN.
module xulie_ser
   import xulie_pkg::*;
#(
   parameter int WIDTH = XULIE_SER_WIDTH_DEF
)(
   input  logic       clk,
   input  logic       reset,
   xulie_ser_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   xulie_ser_state_t state_reg, state_next;
   logic [WIDTH-1:0] sreg_reg, sreg_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             dout_reg, dout_next;
   logic             dvalid_reg, dvalid_next;
   logic             ready_reg, ready_next;
   logic             done_reg, done_next;

   // Register all state and outputs; active-low synchronous reset aborts any frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         sreg_reg   <= '0;
         cnt_reg    <= '0;
         dout_reg   <= XULIE_IDLE_LEVEL;
         dvalid_reg <= 1'b0;
         ready_reg  <= 1'b1;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         sreg_reg   <= sreg_next;
         cnt_reg    <= cnt_next;
         dout_reg   <= dout_next;
         dvalid_reg <= dvalid_next;
         ready_reg  <= ready_next;
         done_reg   <= done_next;
      end
   end

   // Next-state logic: the MSB goes straight to dout on load, so the shift
   // register only holds the remaining WIDTH-1 bits and cnt counts them.
   always_comb begin
      state_next  = state_reg;
      sreg_next   = sreg_reg;
      cnt_next    = cnt_reg;
      dout_next   = dout_reg;
      dvalid_next = dvalid_reg;
      ready_next  = ready_reg;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.load) begin
               dout_next   = bus.pdata[WIDTH-1];
               dvalid_next = 1'b1;
               ready_next  = 1'b0;
               sreg_next   = bus.pdata << 1;
               cnt_next    = CW'(WIDTH - 1);
               state_next  = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_reg != '0) begin
               dout_next = sreg_reg[WIDTH-1];
               sreg_next = sreg_reg << 1;
               cnt_next  = cnt_reg - CW'(1);
            end else begin
               dout_next   = XULIE_IDLE_LEVEL;
               dvalid_next = 1'b0;
               done_next   = 1'b1;
               ready_next  = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.ready  = ready_reg;
   assign bus.dout   = dout_reg;
   assign bus.dvalid = dvalid_reg;
   assign bus.done   = done_reg;

`ifdef XULIE_SER_CNT_EN
   logic [7:0] frame_cnt_reg;

   // Count completed frames, advancing on the same edge that raises done.
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt_reg <= 8'd0;
      end else if (done_next) begin
         frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
   end

   assign bus.frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_xulie_ser.sv
// Self-checking bench for xulie_ser: directed frames from the test plan
// plus randomized frames with random mid-frame loads, resets and
// back-to-back chaining. Expected bits come from the loaded word.
module tb_xulie_ser;

   localparam int W = 16;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   frames_done;
   int   frame_no;

   xulie_ser_if #(.WIDTH(W)) bus ();

   xulie_ser #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic exp_done);
      check({tag, "_ready"}, 32'(bus.ready), 32'd1);
      check({tag, "_dout"}, 32'(bus.dout), 32'd0);
      check({tag, "_dvalid"}, 32'(bus.dvalid), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
`ifdef XULIE_SER_CNT_EN
      check({tag, "_fcnt"}, 32'(bus.frame_cnt), 32'(frames_done % 256));
`endif
   endtask

   // One frame starting at a negedge with the block idle.
   // noise: 0 none, 1 random load/pdata during the frame, 2 load of 16'hFFFF at bit 7.
   // abort_k: bit index after which reset is applied (-1 = no abort).
   // chain: leave the next load to the caller in the done cycle.
   task automatic run_frame(input logic [W-1:0] d, input int noise, input int abort_k, input bit chain);
      bit aborted;
      aborted = 1'b0;
      frame_no++;
      check("pre_ready", 32'(bus.ready), 32'd1);
      bus.load  = 1'b1;
      bus.pdata = d;
      @(negedge clk);
      bus.load  = 1'b0;
      for (int k = 0; k < W; k++) begin
         check($sformatf("bit%0d_dout", k), 32'(bus.dout), 32'(d[W-1-k]));
         check($sformatf("bit%0d_dvalid", k), 32'(bus.dvalid), 32'd1);
         check($sformatf("bit%0d_ready", k), 32'(bus.ready), 32'd0);
         check($sformatf("bit%0d_done", k), 32'(bus.done), 32'd0);
         if (k == abort_k) begin
            reset    = 1'b0;
            bus.load = 1'b1;
            bus.pdata = 16'(~d);
            @(negedge clk);
            frames_done = 0;
            check_idle("abort", 1'b0);
            reset    = 1'b1;
            bus.load = 1'b0;
            @(negedge clk);
            check_idle("post_abort", 1'b0);
            aborted = 1'b1;
            break;
         end
         if (noise == 1) begin
            bus.load  = 1'($urandom_range(0, 1));
            bus.pdata = 16'($urandom);
         end else if (noise == 2) begin
            bus.load  = (k == 7);
            bus.pdata = 16'hFFFF;
         end
         @(negedge clk);
      end
      if (!aborted) begin
         bus.load = 1'b0;
         frames_done++;
         check_idle("done_cycle", 1'b1);
         if (!chain) begin
            @(negedge clk);
            check_idle("after_done", 1'b0);
         end
      end
      $display("frame %0d data=%h noise=%0d chain=%0d %s", frame_no, d, noise, chain,
               aborted ? "aborted" : "complete");
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      frames_done = 0;
      frame_no    = 0;
      reset       = 1'b0;
      bus.load    = 1'b1;
      bus.pdata   = 16'hA5A5;

      // Reset held for two cycles with load asserted.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_idle("reset", 1'b0);
      end
      reset    = 1'b1;
      bus.load = 1'b0;
      @(negedge clk);
      check_idle("idle", 1'b0);

      // Directed frames.
      run_frame(16'h5F74, 0, -1, 1'b0);
      run_frame(16'h5F74, 2, -1, 1'b0);
      run_frame(16'hE000, 0, -1, 1'b1);
      run_frame(16'h000E, 0, -1, 1'b0);
      run_frame(16'hFFFF, 1, 5, 1'b0);
      run_frame(16'h1234, 0, -1, 1'b0);

      // Randomized frames.
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] d;
         int ab;
         d  = 16'($urandom);
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, W - 2)) : -1;
         run_frame(d, int'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)));
      end
      bus.load = 1'b0;
      @(negedge clk);
      check_idle("rand_end", 1'b0);

`ifdef XULIE_SER_CNT_EN
      // Counter wrap: 257 frames from zero, then a reset during frame 258.
      reset = 1'b0;
      @(negedge clk);
      frames_done = 0;
      reset = 1'b1;
      for (int n = 0; n < 257; n++) begin
         run_frame(16'($urandom), 0, -1, 1'b1);
      end
      check("fcnt_257", 32'(bus.frame_cnt), 32'd1);
      run_frame(16'hBEEF, 0, 6, 1'b0);
      check("fcnt_reset", 32'(bus.frame_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
